// File: rtl/updown_counter_gen.sv
// updown_counter_gen: prescaled up/down counter with modulus, wrap/saturate, load and limit reporting
module updown_counter_gen #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 50_000_000,
  parameter int MAX_VAL  = 15,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             wrap,
  output logic             at_limit
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PC_TOP = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX_VAL);
  localparam bit SAT = SATURATE != 0;
  logic [PW-1:0] pc;
  logic [1:0] en_r, dir_r;
  logic en_s, dir_s, lim, step;
  logic [WIDTH-1:0] q_step, q_next;
  assign en_s = en_r[1];
  assign dir_s = dir_r[1];
  assign at_limit = dir_s ? q == TOP : q == '0;
  always_comb begin
    lim = at_limit;
    step = tick && en_s && !(SAT && lim);
    q_step = dir_s ? (q >= TOP ? '0 : q + WIDTH'(1)) : (q == '0 ? TOP : q - WIDTH'(1));
    q_next = load ? (load_val > TOP ? TOP : load_val) : step ? q_step : q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_r <= '0;
      dir_r <= '0;
      pc <= '0;
      tick <= 1'b0;
      q <= '0;
      wrap <= 1'b0;
    end else begin
      en_r <= {en_r[0], en};
      dir_r <= {dir_r[0], dir};
      pc <= (load || pc == PC_TOP) ? '0 : pc + PW'(1);
      // a load restarts the prescale period, so suppress the tick it would have produced
      tick <= !load && pc == PC_TOP;
      q <= q_next;
      wrap <= !SAT && !load && step && lim;
    end
  end
endmodule

// File: tb/tb_updown_counter_gen.sv
// tb_updown_counter_gen: random stimulus on wrap and saturate instances against a behavioural model
module tb_updown_counter_gen;
  localparam int W = 4, P = 4, M = 9;
  logic clk = 0, reset = 1, en = 0, dir = 0, load = 0;
  logic [W-1:0] load_val = 0;
  logic [W-1:0] q0, q1;
  logic t0, t1, w0, w1, l0, l1;
  int checks = 0, errors = 0;
  int mq[2];
  bit mw[2];
  bit mt, e1, e2, d1, d2;
  int ph;
  always #5 clk = ~clk;
  updown_counter_gen #(.WIDTH(W), .PRESCALE(P), .MAX_VAL(M), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .q(q0), .tick(t0), .wrap(w0), .at_limit(l0));
  updown_counter_gen #(.WIDTH(W), .PRESCALE(P), .MAX_VAL(M), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .q(q1), .tick(t1), .wrap(w1), .at_limit(l1));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic m_reset;
    mq = '{0, 0};
    mw = '{0, 0};
    mt = 0; ph = 0; e1 = 0; e2 = 0; d1 = 0; d2 = 0;
  endtask
  task automatic m_step;
    bit stp, lim;
    stp = mt && e2;
    for (int k = 0; k < 2; k++) begin
      if (load) begin
        mq[k] = load_val > M ? M : int'(load_val);
        mw[k] = 0;
      end else if (stp) begin
        lim = d2 ? mq[k] == M : mq[k] == 0;
        if (k == 1 && lim) mw[k] = 0;
        else begin
          mw[k] = lim;
          mq[k] = d2 ? (mq[k] + 1) % (M + 1) : (mq[k] + M) % (M + 1);
        end
      end else mw[k] = 0;
    end
    mt = !load && ph == P - 1;
    ph = load ? 0 : (ph + 1) % P;
    e2 = e1; e1 = en; d2 = d1; d1 = dir;
  endtask
  task automatic check_all;
    int lim0, lim1;
    lim0 = d2 ? int'(mq[0] == M) : int'(mq[0] == 0);
    lim1 = d2 ? int'(mq[1] == M) : int'(mq[1] == 0);
    chk("q_wrap", q0, mq[0]);
    chk("q_sat", q1, mq[1]);
    chk("wrap_wrap", w0, mw[0]);
    chk("wrap_sat", w1, mw[1]);
    chk("limit_wrap", l0, lim0);
    chk("limit_sat", l1, lim1);
    chk("tick_wrap", t0, mt);
    chk("tick_sat", t1, mt);
  endtask
  task automatic cyc;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
  endtask
  task automatic mid_reset;
    #2 reset = 1;
    #1;
    chk("rst_q_wrap", q0, 0);
    chk("rst_q_sat", q1, 0);
    chk("rst_wrap", w0, 0);
    chk("rst_tick", t0, 0);
    m_reset();
    @(negedge clk);
    reset = 0;
  endtask
  initial begin
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    check_all();
    reset = 0;
    en = 1; dir = 1;
    for (int i = 0; i < 60; i++) cyc();
    dir = 0; load = 1; load_val = 2;
    cyc();
    load = 0;
    for (int i = 0; i < 30; i++) cyc();
    dir = 1; load = 1; load_val = 8;
    cyc();
    load = 0;
    for (int i = 0; i < 30; i++) cyc();
    while (!t0) cyc();
    load = 1; load_val = 13;
    cyc();
    load = 0;
    for (int i = 0; i < 10; i++) cyc();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 19) == 0) en = ~en;
      load = $urandom_range(0, 24) == 0;
      load_val = W'($urandom_range(0, 15));
      cyc();
      if (i % 400 == 399) mid_reset();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
